prog_loader: RTL and testbench

- Front end of the program-load handshake. Takes bytes from the UART receiver and packs them into 32-bit instruction words.
- Writes each word into instruction memory, then raises prog_ready so the program counter starts fetching.
- Holds prog_ready until the program counter answers with prog_ack (end of program), then returns to idle for the next download.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_word_assembler.sv | 54 +++++
 rtl/prog_loader.sv | 214 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-load front end.
// PROG_LOADER_CHECKSUM_EN (see prog_loader.sv) enables the XOR trailer check.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4
    } state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int LEN_BYTES          = 2;
    localparam int ACK_QUAL_CYCLES    = 2;

    function automatic int bytes_per_word_f(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs little-endian bytes into words; word_valid_o is combinational on the
// last byte of a word and word_o carries the completed word in that cycle.
module word_assembler
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8 * BYTES_PER_WORD
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  word_valid_o,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int BPW   = bytes_per_word_f(DATA_WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_byte;
    logic [DATA_WIDTH-1:0] shifted;

    // Bytes enter at the top so byte k ends up in bits [8k+7:8k].
    assign shifted   = {byte_i, shreg_q[DATA_WIDTH-1:8]};
    assign last_byte = (cnt_q == CNT_W'(BPW - 1));

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (byte_valid_i) begin
            shreg_d = shifted;
            cnt_d   = last_byte ? '0 : cnt_q + 1'b1;
        end
    end

    assign word_valid_o = byte_valid_i && last_byte && !clear_i;
    assign word_o       = shifted;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program-load front end: length header, word packing, imem writes, PC handshake.
// Define PROG_LOADER_CHECKSUM_EN to require an XOR trailer byte after the data.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clear,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  prog_ready,
    input  logic                  prog_ack,
    output logic                  load_busy,
    output logic                  load_err,
    output logic                  done,
    output state_e                dbg_state
);

    localparam int          IDX_W     = ADDR_WIDTH + 1;
    localparam int          LEN_W     = 8 * LEN_BYTES;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int          ACK_CNT_W = $clog2(ACK_QUAL_CYCLES) + 1;

    // Handshake: rx_valid is a strobe with no back-pressure, so every byte
    // presented in LEN/LOAD is consumed in its cycle; prog_ready is a level
    // held until a qualified prog_ack level, answered by a one-cycle done.

    state_e                 state_q, state_d;
    logic [7:0]             len_lo_q, len_lo_d;
    logic [IDX_W-1:0]       word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]       word_idx_q, word_idx_d;
    logic                   stage_valid_q, stage_valid_d;
    logic [DATA_WIDTH-1:0]  stage_data_q, stage_data_d;
    logic                   last_asm_q, last_asm_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [ACK_CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]             xor_q, xor_d;
`endif

    logic                  asm_valid;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic [LEN_W-1:0]      n_full;
    logic                  len_bad;
    logic                  ack_qual;

    assign n_full    = {rx_data, len_lo_q};
    assign len_bad   = (n_full == '0) || (32'(n_full) > DEPTH);
    assign asm_valid = rx_valid && (state_q == LOAD) && !last_asm_q;
    assign ack_qual  = prog_ack && (ack_cnt_q >= ACK_CNT_W'(ACK_QUAL_CYCLES - 1));

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk          (clk),
        .arst_n       (arst_n),
        .clear_i      (clear),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d       = state_q;
        len_lo_d      = len_lo_q;
        word_cnt_d    = word_cnt_q;
        word_idx_d    = word_idx_q;
        stage_valid_d = 1'b0;
        stage_data_d  = stage_data_q;
        last_asm_d    = last_asm_q;
        err_d         = err_q;
        done_d        = 1'b0;
        ack_cnt_d     = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d         = xor_q;
`endif
        if (clear) begin
            state_d    = IDLE;
            err_d      = 1'b0;
            last_asm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        len_lo_d = rx_data;
                        err_d    = 1'b0;
                        state_d  = LEN;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        if (len_bad) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            word_cnt_d = IDX_W'(n_full);
                            word_idx_d = '0;
                            last_asm_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            xor_d      = '0;
`endif
                            state_d    = LOAD;
                        end
                    end
                end
                LOAD: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (asm_valid) xor_d = xor_q ^ rx_data;
`endif
                    if (word_valid) begin
                        stage_valid_d = 1'b1;
                        stage_data_d  = word;
                        if (word_idx_q == word_cnt_q - 1'b1) last_asm_d = 1'b1;
                    end
                    // last_asm_q is only ever set for the cycle of the final write.
                    if (stage_valid_q) begin
                        word_idx_d = word_idx_q + 1'b1;
                        if (last_asm_q) begin
                            last_asm_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            if (rx_valid) begin
                                if (rx_data == xor_q) begin
                                    state_d = RUN;
                                end else begin
                                    err_d   = 1'b1;
                                    state_d = IDLE;
                                end
                            end else begin
                                state_d = CHECK;
                            end
`else
                            state_d = RUN;
`endif
                        end
                    end
                end
                CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        if (rx_data == xor_q) begin
                            state_d = RUN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
`else
                    state_d = IDLE;
`endif
                end
                RUN: begin
                    ack_cnt_d = ack_cnt_q;
                    if (ack_cnt_q < ACK_CNT_W'(ACK_QUAL_CYCLES - 1)) ack_cnt_d = ack_cnt_q + 1'b1;
                    if (ack_qual) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            len_lo_q      <= '0;
            word_cnt_q    <= '0;
            word_idx_q    <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            last_asm_q    <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            ack_cnt_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            len_lo_q      <= len_lo_d;
            word_cnt_q    <= word_cnt_d;
            word_idx_q    <= word_idx_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            last_asm_q    <= last_asm_d;
            err_q         <= err_d;
            done_q        <= done_d;
            ack_cnt_q     <= ack_cnt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q         <= xor_d;
`endif
        end
    end

    assign imem_we    = stage_valid_q;
    assign imem_addr  = word_idx_q[ADDR_WIDTH-1:0];
    assign imem_wdata = stage_data_q;
    assign prog_ready = (state_q == RUN);
    assign load_busy  = (state_q == LEN) || (state_q == LOAD);
    assign load_err   = err_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame loads, length errors, clear, reset in RUN.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;

  // clock/reset
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          prog_ack = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          prog_ready;
  logic          load_busy;
  logic          load_err;
  logic          done;
  state_e        dbg_state;

  prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .clear      (clear),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .prog_ready (prog_ready),
    .prog_ack   (prog_ack),
    .load_busy  (load_busy),
    .load_err   (load_err),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_a_q[$];
  logic [DW-1:0] obs_q[$];
  logic [AW-1:0] obs_a_q[$];
  int cyc = 0;
  int last_we_cyc = -1;
  int rise_cyc = -1;
  int fall_cyc = -1;
  int done_cyc = -1;
  logic ready_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      obs_a_q.push_back(imem_addr);
      obs_q.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
    if (prog_ready && !ready_prev) rise_cyc = cyc;
    if (!prog_ready && ready_prev) fall_cyc = cyc;
    if (done) done_cyc = cyc;
    ready_prev = prog_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      chk({tag, "_addr"}, 64'(obs_a_q.pop_front()), 64'(exp_a_q.pop_front()));
      chk({tag, "_data"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    end
    exp_q.delete();
    exp_a_q.delete();
    obs_q.delete();
    obs_a_q.delete();
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_trailer(input logic [7:0] b);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(b);
`else
    if (b == 8'hxx) tick(0);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!prog_ready && k < 20) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(prog_ready), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 20) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_we",    64'(imem_we),    64'd0);
    chk("rst_ready", 64'(prog_ready), 64'd0);
    chk("rst_busy",  64'(load_busy),  64'd0);
    chk("rst_err",   64'(load_err),   64'd0);
    chk("rst_done",  64'(done),       64'd0);
    chk("rst_state", 64'(dbg_state),  64'(IDLE));
    arst_n = 1'b1;
    tick(1);

    // two-word frame, ack held from the start of RUN
    send_byte(8'h02);
    send_byte(8'h00);
    chk("hdr_busy",  64'(load_busy), 64'd1);
    chk("hdr_state", 64'(dbg_state), 64'(LOAD));
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_trailer(8'h2A);
    exp_a_q.push_back(10'd0); exp_q.push_back(32'h12345678);
    exp_a_q.push_back(10'd1); exp_q.push_back(32'hDEADBEEF);
    prog_ack = 1'b1;
    wait_done("two_done_seen");
    tick(1);
    prog_ack = 1'b0;
    chk_writes("two_wr");
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("ready_after_write", 64'(rise_cyc), 64'(last_we_cyc + 1));
`endif
    chk("done_timing",  64'(done_cyc), 64'(rise_cyc + 2));
    chk("ready_fall",   64'(fall_cyc), 64'(rise_cyc + 2));
    chk("two_idle",     64'(dbg_state), 64'(IDLE));
    chk("two_ready_lo", 64'(prog_ready), 64'd0);

    // zero-length header
    send_byte(8'h00);
    send_byte(8'h00);
    tick(1);
    chk("n0_err",   64'(load_err),  64'd1);
    chk("n0_state", 64'(dbg_state), 64'(IDLE));
    chk_writes("n0_wr");

    // 1025 words is one over the depth
    send_byte(8'h01);
    chk("err_cleared", 64'(load_err),  64'd0);
    chk("len_state",   64'(dbg_state), 64'(LEN));
    send_byte(8'h04);
    chk("n1025_err",   64'(load_err),  64'd1);
    chk("n1025_state", 64'(dbg_state), 64'(IDLE));

    // 1024 words exactly fits; abort with clear
    send_byte(8'h00);
    send_byte(8'h04);
    chk("n1024_state", 64'(dbg_state), 64'(LOAD));
    chk("n1024_err",   64'(load_err),  64'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_state", 64'(dbg_state), 64'(IDLE));
    chk("clr_busy",  64'(load_busy), 64'd0);

    // clear coincident with the 6th byte of a 2-word frame drops the word
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    clear    = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    clear    = 1'b0;
    tick(3);
    chk("clr6_state", 64'(dbg_state), 64'(IDLE));
    chk("clr6_busy",  64'(load_busy), 64'd0);
    chk_writes("clr6_wr");

    // fresh frame after clear
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_trailer(8'h00);
    exp_a_q.push_back(10'd0); exp_q.push_back(32'hDDCCBBAA);
    wait_ready("fresh_ready");
    chk_writes("fresh_wr");

    // bytes during RUN are ignored
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    tick(2);
    chk("run_ready_held", 64'(prog_ready), 64'd1);
    chk_writes("run_wr");

    // asynchronous reset in RUN
    #3 arst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(prog_ready), 64'd0);
    chk("arst_state", 64'(dbg_state),  64'(IDLE));
    chk("arst_we",    64'(imem_we),    64'd0);
    tick(1);
    arst_n = 1'b1;
    tick(1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // good trailer
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0F);
    exp_a_q.push_back(10'd0); exp_q.push_back(32'h08040201);
    wait_ready("ck_good_ready");
    chk("ck_good_err", 64'(load_err), 64'd0);
    chk_writes("ck_good_wr");
    prog_ack = 1'b1;
    wait_done("ck_done");
    tick(1);
    prog_ack = 1'b0;

    // bad trailer
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h00);
    exp_a_q.push_back(10'd0); exp_q.push_back(32'h08040201);
    tick(2);
    chk("ck_bad_err",   64'(load_err),   64'd1);
    chk("ck_bad_ready", 64'(prog_ready), 64'd0);
    chk("ck_bad_state", 64'(dbg_state),  64'(IDLE));
    chk_writes("ck_bad_wr");
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
